target_trigger_ctrl: RTL and testbench
======================================

# target_trigger_ctrl

Arm-and-capture controller that sits directly upstream of the per-channel target counters. It synchronizes the asynchronous sensor comparator inputs, detects rising edges, and issues one start pulse per channel per shot. It issues a common stop pulse when every enabled channel has fired or a capture timeout expires. Status is exposed for the I2C register file.

## Interface
- N_CH, 4, number of sensor channels / counters driven
- SYNC_STAGES, 2, flip-flop stages in each sensor input synchronizer (≥2)
- TMO_W, 16, width of capture timeout value and timer

- clk  in  1  system clock
- reset_n  in  1  hardware reset; reset is asynchronous and active-low
- sensor_in  in  N_CH  raw comparator outputs, asynchronous to clk
- en_mask  in  N_CH  channel enable from I2C reg; quasi-static
- arm  in  1  single-cycle arm request from I2C reg
- clear  in  1  synchronous clear from I2C reg; same pulse that clears the counters
- timeout  in  TMO_W  capture window in clk cycles; 0 = no timeout
- start  out  N_CH  per-channel single-cycle start pulse to counter
- stop  out  1  single-cycle common stop pulse to all counters
- armed  out  1  high in ARMED state
- done  out  1  high in DONE state (interrupt source)
- hit_mask  out  N_CH  channels that fired this shot
- timed_out  out  1  shot ended by timeout rather than all-hit

## Operation
- Each sensor_in bit: SYNC_STAGES-FF synchronizer, then a registered rising-edge detect (sync high, previous low) → edge[i].
- A qualified hit is edge[i] & en_mask[i] & ~hit_mask[i].
- States:
  - IDLE: all edges ignored; arm → ARMED.
  - ARMED: first cycle with any qualified hit → CAPTURE. The start pulse and hit_mask bit are set for every channel qualified in that cycle. The timer loads 0.
  - CAPTURE:
    - Each later qualified hit pulses start[i] and sets hit_mask[i]. The timer increments by 1 per cycle and saturates.
    - When hit_mask covers en_mask, stop pulses on the next cycle → DONE, timed_out=0.
    - When timeout≠0 and timer==timeout with channels still missing, stop pulses that cycle → DONE, timed_out=1. Edges arriving in that cycle are ignored; no start is issued.
  - DONE: edges and arm ignored; hit_mask and timed_out held until clear.
- clear in any state → IDLE next edge. It zeroes hit_mask, timed_out and the timer, and suppresses start/stop that cycle. clear beats arm when both are asserted.
- Edge-based: a sensor already high at arm does not trigger until it falls and rises again.
- en_mask == 0: ARMED never exits except by clear.
- reset_n low: all outputs 0, state IDLE, synchronizers 0, immediately and independent of clk.

## Timing
- Sensor input latency: an input rise first sampled at edge E0 → start[i] high after edge E0+SYNC_STAGES, for exactly 1 cycle.
- All-hit stop: high exactly 1 cycle after the cycle holding the final start. The last counter therefore counts at least 1.
- Timeout stop: the counter of the first channel runs `timeout` cycles.
- arm → armed high after the next edge; first capture possible the cycle after.
- start and stop are never high in the same cycle.
- done/armed are registered and glitch-free; hit_mask updates in the same cycle as the corresponding start.

## Structure
- Shared package target_pkg holds:
  - state enum (IDLE, ARMED, CAPTURE, DONE)
  - N_CH default
  - TMO_W default
- Sub-module target_edge_sync: a single-bit synchronizer plus rising-edge detect, instantiated N_CH times via generate.
- The FSM, timer and hit_mask live in target_trigger_ctrl.

## Test plan
- Basic four-hit shot:
  - Stimulus: arm; channels 0,1,2,3 rise at cycles 10,14,20,25 (timeout=0).
  - Required: start pulses at +2 each; stop one cycle after the ch3 start; done=1, hit_mask=4'hF, timed_out=0.
- Timeout:
  - Stimulus: timeout=50; only ch0 and ch2 fire.
  - Required: stop exactly 50 cycles after the ch0 start; hit_mask=4'h5, timed_out=1. A ch1 edge in the stop cycle gives no start.
- Masking and re-trigger:
  - Stimulus: en_mask=4'h7; ch3 toggles repeatedly and ch0 rises twice.
  - Required: no start[3]; a single start[0]; stop after ch1 and ch2 fire.
- Simultaneous and pre-armed:
  - Stimulus: ch1 and ch2 rise in the same cycle; ch0 is held high before arm.
  - Required: start=4'h6 in one cycle. ch0 fires only after a low→high transition.
- Clear and reset:
  - Stimulus: clear mid-CAPTURE together with an edge; arm+clear in the same cycle; reset_n pulsed low in DONE.
  - Required: returns to IDLE, no start or stop emitted, all outputs 0.

Source files
------------

// File: rtl/target_pkg.sv
// Shared types and defaults for the target trigger controller.
// Imported by the edge synchronizer and the trigger FSM.
package target_pkg;

   localparam int N_CH_DEF  = 4;
   localparam int TMO_W_DEF = 16;

   typedef enum logic [1:0] {
      IDLE,
      ARMED,
      CAPTURE,
      DONE
   } state_e;

endpackage

// File: rtl/target_edge_sync.sv
// Single-bit synchronizer followed by a rising-edge detector.
// rise_o is high for one cycle after the synchronized level goes 0->1.
module target_edge_sync
   import target_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset_n,
   input  logic d_i,
   output logic rise_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/target_trigger_ctrl.sv
// Arm-and-capture controller: per-channel start pulses, common stop,
// capture timeout and status for the register file.
module target_trigger_ctrl
   import target_pkg::*;
#(
   parameter int N_CH        = N_CH_DEF,
   parameter int SYNC_STAGES = 2,
   parameter int TMO_W       = TMO_W_DEF
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [N_CH-1:0]  sensor_in,
   input  logic [N_CH-1:0]  en_mask,
   input  logic             arm,
   input  logic             clear,
   input  logic [TMO_W-1:0] timeout,
   output logic [N_CH-1:0]  start,
   output logic             stop,
   output logic             armed,
   output logic             done,
   output logic [N_CH-1:0]  hit_mask,
   output logic             timed_out
);

   state_e             state_q;
   logic [TMO_W-1:0]   timer_q;
   logic [TMO_W-1:0]   timer_d;
   logic [TMO_W:0]     timer_inc;
   logic [N_CH-1:0]    start_q;
   logic [N_CH-1:0]    hit_q;
   logic               stop_q;
   logic               armed_q;
   logic               done_q;
   logic               tmo_q;

   logic [N_CH-1:0]    rise;
   logic [N_CH-1:0]    qual;
   logic               all_hit;
   logic               tmo_hit;

   for (genvar g = 0; g < N_CH; g++) begin : g_sync
      target_edge_sync #(
         .SYNC_STAGES(SYNC_STAGES)
      ) u_sync (
         .clk    (clk),
         .reset_n(reset_n),
         .d_i    (sensor_in[g]),
         .rise_o (rise[g])
      );
   end

   assign qual    = rise & en_mask & ~hit_q;
   assign all_hit = (hit_q & en_mask) == en_mask;

   // Stop is registered, so fire one cycle early: the stop then lands
   // exactly `timeout` cycles after the first start.
   assign timer_inc = {1'b0, timer_q} + (TMO_W+1)'(1);
   assign tmo_hit   = (timeout != '0) &&
                      (timer_inc == {1'b0, timeout});
   assign timer_d   = (&timer_q) ? timer_q
                                 : timer_q + TMO_W'(1);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         timer_q <= '0;
         start_q <= '0;
         hit_q   <= '0;
         stop_q  <= 1'b0;
         armed_q <= 1'b0;
         done_q  <= 1'b0;
         tmo_q   <= 1'b0;
      end else begin
         start_q <= '0;
         stop_q  <= 1'b0;
         if (clear) begin
            state_q <= IDLE;
            timer_q <= '0;
            hit_q   <= '0;
            armed_q <= 1'b0;
            done_q  <= 1'b0;
            tmo_q   <= 1'b0;
         end else begin
            unique case (state_q)
               IDLE: begin
                  if (arm) begin
                     state_q <= ARMED;
                     armed_q <= 1'b1;
                  end
               end
               ARMED: begin
                  if (|qual) begin
                     state_q <= CAPTURE;
                     armed_q <= 1'b0;
                     start_q <= qual;
                     hit_q   <= hit_q | qual;
                     timer_q <= '0;
                  end
               end
               CAPTURE: begin
                  if (all_hit) begin
                     state_q <= DONE;
                     stop_q  <= 1'b1;
                     done_q  <= 1'b1;
                     tmo_q   <= 1'b0;
                  end else if (tmo_hit) begin
                     state_q <= DONE;
                     stop_q  <= 1'b1;
                     done_q  <= 1'b1;
                     tmo_q   <= 1'b1;
                  end else begin
                     start_q <= qual;
                     hit_q   <= hit_q | qual;
                     timer_q <= timer_d;
                  end
               end
               DONE: begin
                  state_q <= DONE;
               end
               default: begin
                  state_q <= IDLE;
               end
            endcase
         end
      end
   end

   assign start     = start_q;
   assign stop      = stop_q;
   assign armed     = armed_q;
   assign done      = done_q;
   assign hit_mask  = hit_q;
   assign timed_out = tmo_q;

endmodule

// File: tb/tb_target_trigger_ctrl.sv
// Bench for target_trigger_ctrl: directed shots plus random shots
// checked against an event-time model of the capture rules.
module tb_target_trigger_ctrl;
   import target_pkg::*;

   localparam int N    = 4;
   localparam int KMAX = 256;

   logic          clk;
   logic          reset_n;
   logic [N-1:0]  sensor_in;
   logic [N-1:0]  en_mask;
   logic          arm;
   logic          clear;
   logic [15:0]   timeout;
   logic [N-1:0]  start;
   logic          stop;
   logic          armed;
   logic          done;
   logic [N-1:0]  hit_mask;
   logic          timed_out;

   int errors = 0;
   int checks = 0;
   int last_stop;

   logic [N-1:0] xs   [KMAX];
   logic [N-1:0] st_e [KMAX];
   logic [N-1:0] hm_e [KMAX];
   bit           sp_e [KMAX];
   bit           ar_e [KMAX];
   bit           dn_e [KMAX];
   bit           to_e [KMAX];

   target_trigger_ctrl #(
      .N_CH(N), .SYNC_STAGES(2), .TMO_W(16)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .sensor_in(sensor_in),
      .en_mask  (en_mask),
      .arm      (arm),
      .clear    (clear),
      .timeout  (timeout),
      .start    (start),
      .stop     (stop),
      .armed    (armed),
      .done     (done),
      .hit_mask (hit_mask),
      .timed_out(timed_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] want);
      checks++;
      assert (obs === want) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
      end
   endtask

   // Sensor level driven for clock edge k; before the window it holds xs[0].
   function automatic bit xv(int i, int k);
      if (k < 0) return xs[0][i];
      return xs[k][i];
   endfunction

   // A 0->1 at edges k-3/k-2 can produce a start visible after edge k.
   function automatic bit ev(int i, int k);
      return xv(i, k-2) && !xv(i, k-3);
   endfunction

   task automatic model(input int a, input int t,
                        input logic [N-1:0] en, input int K);
      int c, lim, last, stp;
      int first [N];
      bit all;
      logic [N-1:0] acc;
      for (int k = 0; k < KMAX; k++) begin
         st_e[k] = '0; hm_e[k] = '0;
         sp_e[k] = 0; ar_e[k] = 0; dn_e[k] = 0; to_e[k] = 0;
      end
      c = -1;
      for (int k = a+1; k < K && c < 0; k++)
         for (int i = 0; i < N; i++)
            if (en[i] && ev(i, k)) c = k;
      for (int k = a; k < K; k++) ar_e[k] = (c < 0) || (k < c);
      if (c < 0) return;
      lim  = (t != 0) ? c + t - 1 : K - 1;
      all  = 1;
      last = c;
      for (int i = 0; i < N; i++) begin
         first[i] = -1;
         if (en[i]) begin
            for (int k = c; k <= lim && k < K; k++)
               if (first[i] < 0 && ev(i, k)) first[i] = k;
            if (first[i] < 0) all = 0;
            else begin
               st_e[first[i]][i] = 1'b1;
               if (first[i] > last) last = first[i];
            end
         end
      end
      stp = all ? last + 1 : ((t != 0) ? c + t : -1);
      acc = '0;
      for (int k = 0; k < K; k++) begin
         acc     = acc | st_e[k];
         hm_e[k] = acc;
         if (stp >= 0 && k >= stp) begin
            dn_e[k] = 1;
            to_e[k] = !all;
         end
         if (k == stp) sp_e[k] = 1;
      end
   endtask

   task automatic setv(input int ch, input int from, input bit v);
      for (int k = from; k < KMAX; k++) xs[k][ch] = v;
   endtask

   task automatic zero_x();
      for (int k = 0; k < KMAX; k++) xs[k] = '0;
   endtask

   task automatic step(input logic [N-1:0] s, input logic a,
                       input logic c);
      sensor_in = s; arm = a; clear = c;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic run_shot(input string nm, input int a, input int t,
                           input logic [N-1:0] en, input int K);
      model(a, t, en, K);
      en_mask = en;
      timeout = 16'(t);
      step(xs[0], 1'b0, 1'b1);
      repeat (3) step(xs[0], 1'b0, 1'b0);
      last_stop = -1;
      for (int k = 0; k < K; k++) begin
         step(xs[k], (k == a), 1'b0);
         chk($sformatf("%s.start@%0d", nm, k), 32'(start), 32'(st_e[k]));
         chk($sformatf("%s.stop@%0d", nm, k), 32'(stop), 32'(sp_e[k]));
         chk($sformatf("%s.armed@%0d", nm, k), 32'(armed), 32'(ar_e[k]));
         chk($sformatf("%s.done@%0d", nm, k), 32'(done), 32'(dn_e[k]));
         chk($sformatf("%s.hit@%0d", nm, k), 32'(hit_mask), 32'(hm_e[k]));
         chk($sformatf("%s.tmo@%0d", nm, k), 32'(timed_out), 32'(to_e[k]));
         if (stop === 1'b1 && last_stop < 0) last_stop = k;
      end
   endtask

   initial begin
      reset_n   = 1'b0;
      sensor_in = '0;
      en_mask   = '0;
      arm       = 1'b0;
      clear     = 1'b0;
      timeout   = '0;
      #3;
      chk("reset_outputs",
          32'({start, stop, armed, done, hit_mask, timed_out}), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;

      // basic four-hit shot
      zero_x();
      setv(0, 10, 1); setv(1, 14, 1); setv(2, 20, 1); setv(3, 25, 1);
      run_shot("basic", 2, 0, 4'hF, 100);
      chk("basic_stop_cycle", 32'(last_stop), 32'd28);
      chk("basic_hit", 32'(hit_mask), 32'hF);
      chk("basic_tmo", 32'(timed_out), 32'd0);

      // timeout with a ch1 edge landing in the stop cycle
      zero_x();
      setv(0, 10, 1); setv(2, 30, 1); setv(1, 60, 1);
      run_shot("timeout", 2, 50, 4'hF, 100);
      chk("tmo_stop_cycle", 32'(last_stop), 32'd62);
      chk("tmo_hit", 32'(hit_mask), 32'h5);
      chk("tmo_flag", 32'(timed_out), 32'd1);

      // masking and re-trigger
      zero_x();
      for (int k = 4; k < KMAX; k++) xs[k][3] = ((k / 3) % 2 == 1);
      setv(0, 10, 1); setv(0, 15, 0); setv(0, 20, 1);
      setv(1, 30, 1); setv(2, 40, 1);
      run_shot("mask", 2, 0, 4'h7, 100);
      chk("mask_stop_cycle", 32'(last_stop), 32'd43);
      chk("mask_hit", 32'(hit_mask), 32'h7);

      // simultaneous and pre-armed
      zero_x();
      setv(0, 0, 1); setv(1, 10, 1); setv(2, 10, 1);
      setv(0, 20, 0); setv(0, 25, 1); setv(3, 30, 1);
      run_shot("simul", 2, 0, 4'hF, 100);
      chk("simul_stop_cycle", 32'(last_stop), 32'd33);

      // en_mask == 0 stays armed
      zero_x();
      setv(0, 10, 1); setv(1, 12, 1);
      run_shot("nomask", 2, 0, 4'h0, 60);
      chk("nomask_armed", 32'(armed), 32'd1);

      // clear mid-capture together with an edge
      en_mask = 4'hF; timeout = '0;
      step(4'h0, 1'b0, 1'b1);
      repeat (3) step(4'h0, 1'b0, 1'b0);
      step(4'h0, 1'b1, 1'b0);
      chk("clr_armed", 32'(armed), 32'd1);
      step(4'h1, 1'b0, 1'b0);
      step(4'h1, 1'b0, 1'b0);
      step(4'h1, 1'b0, 1'b0);
      chk("clr_first_start", 32'(start), 32'h1);
      step(4'h3, 1'b0, 1'b0);
      step(4'h3, 1'b0, 1'b0);
      step(4'h3, 1'b0, 1'b1);
      chk("clr_outputs",
          32'({start, stop, armed, done, hit_mask, timed_out}), 32'd0);
      step(4'h3, 1'b0, 1'b0);
      chk("clr_after", 32'({start, armed, hit_mask}), 32'd0);

      // arm and clear together: clear wins
      step(4'h0, 1'b1, 1'b1);
      chk("armclr_armed", 32'(armed), 32'd0);
      step(4'h0, 1'b0, 1'b0);
      chk("armclr_idle", 32'(armed), 32'd0);

      // async reset while in DONE
      en_mask = 4'h1;
      step(4'h0, 1'b1, 1'b0);
      step(4'h1, 1'b0, 1'b0);
      step(4'h1, 1'b0, 1'b0);
      step(4'h1, 1'b0, 1'b0);
      chk("rst_start", 32'(start), 32'h1);
      step(4'h1, 1'b0, 1'b0);
      chk("rst_stop", 32'({stop, done}), 32'h3);
      step(4'h1, 1'b0, 1'b0);
      chk("rst_done_held", 32'({stop, done, hit_mask}), 32'h11);
      #2 reset_n = 1'b0;
      #1;
      chk("rst_async_outputs",
          32'({start, stop, armed, done, hit_mask, timed_out}), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;

      // random shots
      for (int s = 0; s < 20; s++) begin
         logic [N-1:0] en;
         int t;
         en = 4'($urandom_range(0, 15));
         t  = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 80));
         xs[0] = 4'($urandom_range(0, 15));
         for (int k = 1; k < KMAX; k++) begin
            xs[k] = xs[k-1];
            for (int i = 0; i < N; i++)
               if ($urandom_range(0, 11) == 0) xs[k][i] = ~xs[k][i];
         end
         run_shot($sformatf("rnd%0d", s), int'($urandom_range(1, 10)),
                  t, en, 200);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
